// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: four-floor lift controller with a collective (SCAN) policy.
// Call buttons are ORed into a pending register. The car keeps its direction while
// calls remain ahead of it and reverses when none do. One shared down-counter times
// both the floor-to-floor travel and the door-open interval.
module lift_call_scheduler #(
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] call,
    input  logic       door_hold,
    output logic [1:0] floor,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2
    } state_t;

    localparam logic [3:0] TRAVEL_LOAD = 4'(TRAVEL_CYC - 1);
    localparam logic [3:0] DOOR_LOAD   = 4'(DOOR_CYC - 1);

    state_t     r_state;
    logic [3:0] r_timer;
    logic [1:0] r_floor;
    logic       r_dir_up;
    logic [3:0] r_pending;

    state_t     w_state_n;
    logic [3:0] w_timer_n;
    logic [1:0] w_floor_n;
    logic       w_dir_up_n;
    logic [3:0] w_pending_n;
    logic [3:0] w_serve_mask;

    logic [1:0] w_next_floor;
    logic [3:0] w_above_mask;
    logic [3:0] w_below_mask;
    logic [3:0] w_beyond_mask;
    logic       w_calls_above;
    logic       w_calls_below;
    logic       w_calls_beyond;

    // Floor the car reaches when the current one-floor step completes.
    assign w_next_floor = r_dir_up ? (r_floor + 2'd1) : (r_floor - 2'd1);

    // Floor masks: strictly above/below the car, and strictly beyond the arrival floor in the travel direction.
    always_comb begin
        w_above_mask  = '0;
        w_below_mask  = '0;
        w_beyond_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_above_mask[i]  = (2'(i) > r_floor);
            w_below_mask[i]  = (2'(i) < r_floor);
            w_beyond_mask[i] = r_dir_up ? (2'(i) > w_next_floor) : (2'(i) < w_next_floor);
        end
    end

    assign w_calls_above  = |(r_pending & w_above_mask);
    assign w_calls_below  = |(r_pending & w_below_mask);
    assign w_calls_beyond = |(r_pending & w_beyond_mask);

    // Next-state logic: scheduling decisions use the latched calls only; new calls join next cycle.
    always_comb begin
        w_state_n    = r_state;
        w_timer_n    = r_timer;
        w_floor_n    = r_floor;
        w_dir_up_n   = r_dir_up;
        w_serve_mask = '0;

        case (r_state)
            S_IDLE: begin
                if (r_pending[r_floor]) begin
                    w_state_n    = S_DOOR;
                    w_timer_n    = DOOR_LOAD;
                    w_serve_mask = 4'(1) << r_floor;
                end else if (w_calls_above || w_calls_below) begin
                    w_dir_up_n = r_dir_up ? w_calls_above : !w_calls_below;
                    w_state_n  = S_MOVING;
                    w_timer_n  = TRAVEL_LOAD;
                end
            end

            S_MOVING: begin
                if (r_timer != 4'd0) begin
                    w_timer_n = r_timer - 4'd1;
                end else begin
                    w_floor_n = w_next_floor;
                    if (r_pending[w_next_floor]) begin
                        w_state_n    = S_DOOR;
                        w_timer_n    = DOOR_LOAD;
                        w_serve_mask = 4'(1) << w_next_floor;
                    end else if (w_calls_beyond) begin
                        w_timer_n = TRAVEL_LOAD;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end

            S_DOOR: begin
                w_serve_mask = 4'(1) << r_floor;
                if (door_hold || call[r_floor]) begin
                    w_timer_n = DOOR_LOAD;
                end else if (r_timer != 4'd0) begin
                    w_timer_n = r_timer - 4'd1;
                end else begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_timer_n = '0;
            end
        endcase

        w_pending_n = (r_pending | call) & ~w_serve_mask;
    end

    // State, timer, position, direction and call register; reset aborts any travel or door cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_floor   <= '0;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_floor   <= w_floor_n;
            r_dir_up  <= w_dir_up_n;
            r_pending <= w_pending_n;
        end
    end

    assign floor     = r_floor;
    assign dir_up    = r_dir_up;
    assign moving    = (r_state == S_MOVING);
    assign door_open = (r_state == S_DOOR);
    assign pending   = r_pending;
    assign busy      = (r_state != S_IDLE) || (r_pending != 4'd0);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: scenario tasks plus a randomized run, all checked against
// a trip-level reference model that tracks cycles left in the current step or door.
module tb_lift_call_scheduler;

    localparam int TRAVEL_CYC = 4;
    localparam int DOOR_CYC   = 3;
    localparam int M_IDLE   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DOOR   = 2;
    localparam logic [9:0] RESET_OUT = {2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};

    logic       clk;
    logic       rst_n;
    logic [3:0] call;
    logic       door_hold;
    logic [1:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [3:0] pending;
    logic       busy;

    int compared;
    int mismatched;

    int         mFloor;
    bit         mUp;
    int         mMode;
    int         mLeft;
    logic [3:0] mPending;

    wire [9:0] dutOut = {floor, dir_up, moving, door_open, pending, busy};

    lift_call_scheduler #(.TRAVEL_CYC(TRAVEL_CYC), .DOOR_CYC(DOOR_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .call(call), .door_hold(door_hold),
        .floor(floor), .dir_up(dir_up), .moving(moving), .door_open(door_open),
        .pending(pending), .busy(busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit anyBeyond(input int f, input bit up);
        bit r = 0;
        for (int i = 0; i < 4; i++)
            if (mPending[i] && (up ? (i > f) : (i < f))) r = 1;
        return r;
    endfunction

    function automatic logic [9:0] modelOut();
        return {2'(mFloor), mUp, (mMode == M_TRAVEL), (mMode == M_DOOR), mPending,
                (mMode != M_IDLE) || (mPending != 4'd0)};
    endfunction

    task automatic modelReset();
        mFloor = 0; mUp = 1; mMode = M_IDLE; mLeft = 0; mPending = 4'd0;
    endtask

    // One clock edge of the lift seen as trips and door intervals.
    task automatic modelStep(input logic [3:0] c, input bit h);
        logic [3:0] served = 4'd0;
        bit above, below;
        case (mMode)
            M_IDLE: begin
                above = anyBeyond(mFloor, 1);
                below = anyBeyond(mFloor, 0);
                if (mPending[mFloor]) begin
                    mMode = M_DOOR; mLeft = DOOR_CYC; served[mFloor] = 1'b1;
                end else if (above || below) begin
                    mUp   = mUp ? above : !below;
                    mMode = M_TRAVEL; mLeft = TRAVEL_CYC;
                end
            end
            M_TRAVEL: begin
                mLeft--;
                if (mLeft == 0) begin
                    mFloor = mUp ? mFloor + 1 : mFloor - 1;
                    if (mFloor < 0 || mFloor > 3) begin
                        $display("[TB] FAIL model_floor_range: got %0d want 0..3", mFloor);
                        mismatched++;
                        mFloor = (mFloor < 0) ? 0 : 3;
                    end
                    if (mPending[mFloor]) begin
                        mMode = M_DOOR; mLeft = DOOR_CYC; served[mFloor] = 1'b1;
                    end else if (anyBeyond(mFloor, mUp)) begin
                        mLeft = TRAVEL_CYC;
                    end else begin
                        mMode = M_IDLE;
                    end
                end
            end
            default: begin
                served[mFloor] = 1'b1;
                if (h || c[mFloor]) mLeft = DOOR_CYC;
                else begin
                    mLeft--;
                    if (mLeft == 0) mMode = M_IDLE;
                end
            end
        endcase
        mPending = (mPending | c) & ~served;
    endtask

    // Drive one cycle of inputs, advance the model and the DUT by one edge.
    task automatic driveCycle(input logic [3:0] c, input bit h);
        call = c;
        door_hold = h;
        modelStep(c, h);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        call = 4'd0; door_hold = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            call = (k % 2 == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
            compared++;
            if (dutOut !== RESET_OUT) begin
                mismatched++;
                $display("[TB] FAIL reset_hold: got %h want %h", dutOut, RESET_OUT);
            end
        end
        call = 4'd0;
        rst_n = 1'b1;
        modelReset();
        for (int k = 0; k < 3; k++) begin
            driveCycle(4'd0, 0);
            compared++;
            if (dutOut !== modelOut()) begin
                mismatched++;
                $display("[TB] FAIL reset_release: got %h want %h", dutOut, modelOut());
            end
        end
    endtask

    task automatic test_current_floor();
        int doorCycles = 0;
        pulseReset();
        driveCycle(4'b0001, 0);
        compared++;
        if (door_open !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL curfloor_early_door: got %b want 0", door_open);
        end
        for (int k = 0; k < 10; k++) begin
            driveCycle(4'd0, 0);
            if (door_open) doorCycles++;
            compared++;
            if (dutOut !== modelOut()) begin
                mismatched++;
                $display("[TB] FAIL curfloor_cycle%0d: got %h want %h", k, dutOut, modelOut());
            end
            if (k == 0) begin
                compared++;
                if (door_open !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL curfloor_latency: got %b want 1", door_open);
                end
            end
        end
        compared++;
        if (doorCycles != DOOR_CYC || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL curfloor_door_len: got %0d busy %b want %0d busy 0", doorCycles, busy, DOOR_CYC);
        end
    endtask

    task automatic test_single_trip();
        int movCycles = 0;
        int doorCycles = 0;
        pulseReset();
        driveCycle(4'b1000, 0);
        for (int k = 0; k < 40; k++) begin
            driveCycle(4'd0, 0);
            if (moving) movCycles++;
            if (door_open) doorCycles++;
            compared++;
            if (dutOut !== modelOut()) begin
                mismatched++;
                $display("[TB] FAIL trip_cycle%0d: got %h want %h", k, dutOut, modelOut());
            end
        end
        compared++;
        if (movCycles != 3 * TRAVEL_CYC || doorCycles != DOOR_CYC || floor !== 2'd3 || pending !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL trip_summary: got mov %0d door %0d floor %0d pend %h want mov %0d door %0d floor 3 pend 0",
                     movCycles, doorCycles, floor, pending, 3 * TRAVEL_CYC, DOOR_CYC);
        end
    endtask

    task automatic test_scan_order();
        int order[$];
        bit injected = 0;
        bit prevDoor = 0;
        bit done = 0;
        logic [3:0] c;
        pulseReset();
        for (int k = 0; k < 150 && !done; k++) begin
            c = 4'd0;
            if (k == 0) c = 4'b1000;
            else if (!injected && floor == 2'd1) begin
                c = 4'b0101;
                injected = 1;
            end
            driveCycle(c, 0);
            compared++;
            if (dutOut !== modelOut()) begin
                mismatched++;
                $display("[TB] FAIL scan_cycle%0d: got %h want %h", k, dutOut, modelOut());
            end
            if (door_open && !prevDoor) order.push_back(int'(floor));
            prevDoor = door_open;
            if (k > 2 && !busy) done = 1;
        end
        compared++;
        if (!done || order.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL scan_service_count: got %0d stops done %b want 3 stops done 1", order.size(), done);
        end else if (order[0] != 2 || order[1] != 3 || order[2] != 0 || dir_up !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL scan_order: got %0d,%0d,%0d dir %b want 2,3,0 dir 0", order[0], order[1], order[2], dir_up);
        end
    endtask

    task automatic test_door_hold();
        int doorCycles;
        bit opened;
        for (int pass = 0; pass < 2; pass++) begin
            pulseReset();
            doorCycles = 0;
            opened = 0;
            driveCycle(4'b0001, 0);
            for (int k = 0; k < 5 && !opened; k++) begin
                driveCycle(4'd0, 0);
                if (door_open) opened = 1;
            end
            compared++;
            if (!opened) begin
                mismatched++;
                $display("[TB] FAIL hold_door_timeout: got closed want open");
            end
            doorCycles = 1;
            for (int k = 0; k < 5; k++) begin
                if (pass == 0) driveCycle(4'd0, 1);
                else if (k == 0) driveCycle(4'b0001, 0);
                else driveCycle(4'd0, 0);
                if (door_open) doorCycles++;
                compared++;
                if (dutOut !== modelOut() || pending !== 4'd0) begin
                    mismatched++;
                    $display("[TB] FAIL hold_ext%0d_cycle%0d: got %h want %h", pass, k, dutOut, modelOut());
                end
            end
            for (int k = 0; k < 20 && door_open; k++) begin
                driveCycle(4'd0, 0);
                if (door_open) doorCycles++;
            end
            compared++;
            if (doorCycles != (pass == 0 ? 5 + DOOR_CYC : 1 + DOOR_CYC)) begin
                mismatched++;
                $display("[TB] FAIL hold_len%0d: got %0d want %0d", pass, doorCycles,
                         pass == 0 ? 5 + DOOR_CYC : 1 + DOOR_CYC);
            end
        end
    endtask

    task automatic test_reset_mid_travel();
        bit reached = 0;
        pulseReset();
        driveCycle(4'b1000, 0);
        for (int k = 0; k < 30 && !reached; k++) begin
            driveCycle(4'd0, 0);
            if (floor == 2'd1 && moving) reached = 1;
        end
        driveCycle(4'd0, 0);
        compared++;
        if (!reached || pending !== 4'b1000 || moving !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_setup: got floor %0d pend %h mov %b want floor 1 pend 8 mov 1", floor, pending, moving);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (dutOut !== RESET_OUT) begin
            mismatched++;
            $display("[TB] FAIL midreset_async: got %h want %h", dutOut, RESET_OUT);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        for (int k = 0; k < 5; k++) begin
            driveCycle(4'd0, 0);
            compared++;
            if (dutOut !== modelOut() || pending !== 4'd0) begin
                mismatched++;
                $display("[TB] FAIL midreset_after%0d: got %h want %h", k, dutOut, modelOut());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        bit h;
        pulseReset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
                modelReset();
            end
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            h = ($urandom_range(0, 9) == 0);
            driveCycle(c, h);
            compared++;
            if (dutOut !== modelOut()) begin
                mismatched++;
                $display("[TB] FAIL random_cycle%0d: got %h want %h", k, dutOut, modelOut());
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        call = 4'd0;
        door_hold = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        test_reset();
        test_current_floor();
        test_single_trip();
        test_scan_order();
        test_door_hold();
        test_reset_mid_travel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
